logic_unit_iter: RTL and testbench

LOGIC_UNIT_ITER -- requirements
Module: logic_unit_iter

---
 rtl/logic_unit_iter_if.sv | 27 ++
 rtl/logic_unit_iter.sv | 101 ++++++++++
 tb/tb_logic_unit_iter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/logic_unit_iter_if.sv
// Request/response bundle for logic_unit_iter: operand handshake in, result handshake out,
// plus condition codes and busy status.
interface logic_unit_iter_if #(
  parameter int WIDTH = 64
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic [1:0]              op;
  logic                    set_cc;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out;
  logic [2:0]              cf;
  logic                    busy;

  modport master (
    output in_valid, a, b, op, set_cc, out_ready,
    input  in_ready, out_valid, out, cf, busy
  );

  modport slave (
    input  in_valid, a, b, op, set_cc, out_ready,
    output in_ready, out_valid, out, cf, busy
  );
endinterface

// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: one CHUNK-wide slice of AND/OR/XOR/XNOR per cycle,
// result held until handshaken, optional ZF/SF/OF update on completion.
module logic_unit_iter #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  logic_unit_iter_if.slave io_lu
);
  // WIDTH must be a multiple of CHUNK with at least two chunks.
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [N-1:0][CHUNK-1:0] r_a, r_b, r_out;
  logic [1:0]              r_op;
  logic                    r_set_cc;
  logic [CHUNK-1:0]        r_acc;
  logic [2:0]              r_cf;

  logic [CHUNK-1:0]        w_ca, w_cb, w_res, w_acc_nxt;
  logic                    w_last;

  // Current slice and its result; last chunk processed is the top one, so its MSB is the sign.
  always_comb begin
    w_ca = r_a[r_cnt];
    w_cb = r_b[r_cnt];
    case (r_op)
      2'b00:   w_res = w_ca & w_cb;
      2'b01:   w_res = w_ca | w_cb;
      2'b10:   w_res = w_ca ^ w_cb;
      default: w_res = ~(w_ca ^ w_cb);
    endcase
    w_acc_nxt = r_acc | w_res;
    w_last    = (r_cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    io_lu.in_ready    = 1'b0;
    io_lu.out_valid   = 1'b0;
    io_lu.busy        = 1'b1;
    case (r_state)
      IDLE: begin
        io_lu.in_ready = 1'b1;
        io_lu.busy     = 1'b0;
        if (io_lu.in_valid) w_next = RUN;
      end
      RUN:  if (w_last) w_next = DONE;
      DONE: begin
        io_lu.out_valid = 1'b1;
        if (io_lu.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_set_cc <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_out    <= '0;
      r_cf     <= '0;
    end else begin
      case (r_state)
        IDLE: if (io_lu.in_valid) begin
          r_a      <= io_lu.a;
          r_b      <= io_lu.b;
          r_op     <= io_lu.op;
          r_set_cc <= io_lu.set_cc;
          r_cnt    <= '0;
          r_acc    <= '0;
        end
        RUN: begin
          r_out[r_cnt] <= w_res;
          r_acc        <= w_acc_nxt;
          r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
          // Zero flag covers every chunk via the accumulator, not just the final slice.
          if (w_last && r_set_cc) r_cf <= {1'b0, w_res[CHUNK-1], ~|w_acc_nxt};
        end
        default: ;
      endcase
    end
  end

  assign io_lu.out = r_out;
  assign io_lu.cf  = r_cf;
endmodule

// File: tb/tb_logic_unit_iter.sv
// Directed bench for logic_unit_iter (WIDTH=64, CHUNK=16): hand-computed vectors,
// latency, hold stability, condition-code persistence, async reset, back-to-back accepts.
module tb_logic_unit_iter;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total    = 0;

  always #5 clk = ~clk;

  logic_unit_iter_if #(.WIDTH(64)) lu ();

  logic_unit_iter #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_lu (lu)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Called at a negedge: presents a request, checks latency N=4, optional hold, then handshake.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic [1:0] top, input logic tsc, input logic [63:0] eout,
                        input logic [2:0] ecf, input int hold);
    lu.a = ta; lu.b = tb_v; lu.op = top; lu.set_cc = tsc; lu.in_valid = 1'b1;
    chk({tag, " in_ready"}, 64'(lu.in_ready), 64'd1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        lu.in_valid = 1'b0;
        lu.a = {$urandom, $urandom}; lu.b = {$urandom, $urandom};
        lu.op = ~top; lu.set_cc = ~tsc;
        chk({tag, " busy"}, 64'(lu.busy), 64'd1);
      end
      if (k == 3) chk({tag, " early_valid"}, 64'(lu.out_valid), 64'd0);
      if (k == 4) chk({tag, " valid"}, 64'(lu.out_valid), 64'd1);
    end
    chk({tag, " out"}, lu.out, eout);
    chk({tag, " cf"}, 64'(lu.cf), 64'(ecf));
    for (int h = 0; h < hold; h++) begin
      lu.in_valid = h[0] ? 1'b0 : 1'b1;
      lu.a = ~ta; lu.op = 2'b01; lu.set_cc = 1'b1;
      @(negedge clk);
      chk({tag, " hold_valid"}, 64'(lu.out_valid), 64'd1);
      chk({tag, " hold_out"}, lu.out, eout);
    end
    lu.in_valid  = 1'b0;
    lu.out_ready = 1'b1;
    @(negedge clk);
    lu.out_ready = 1'b0;
    chk({tag, " back_idle"}, 64'(lu.in_ready), 64'd1);
    chk({tag, " cf_persist"}, 64'(lu.cf), 64'(ecf));
  endtask

  initial begin
    logic [63:0] vec [4];
    logic [63:0] exp_cur;
    int          acc_cyc [$];
    int          nv;
    int          seen_out;

    rst = 1'b1;
    lu.in_valid = 1'b0; lu.a = '0; lu.b = '0; lu.op = '0; lu.set_cc = 1'b0; lu.out_ready = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 64'(lu.in_ready), 64'd1);
    chk("rst out_valid", 64'(lu.out_valid), 64'd0);
    chk("rst busy", 64'(lu.busy), 64'd0);
    chk("rst out", lu.out, 64'd0);
    chk("rst cf", 64'(lu.cf), 64'd0);
    rst = 1'b0;

    run_op("xor_sf", 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 2'b10, 1'b1,
           64'hF0F0_0F0F_F0F0_0F0F, 3'b010, 0);
    run_op("xor_zf", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b10, 1'b1,
           64'h0, 3'b001, 0);
    run_op("xnor_nocc", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 0);
    run_op("and_hold", 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1,
           64'h8000_0000_0000_0001, 3'b010, 5);

    // Async reset after edge 2 of a set_cc run: abandons it, clears everything at once.
    lu.a = 64'h0; lu.b = 64'h0; lu.op = 2'b00; lu.set_cc = 1'b1; lu.in_valid = 1'b1;
    @(negedge clk);
    lu.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst out_valid", 64'(lu.out_valid), 64'd0);
    chk("arst out", lu.out, 64'd0);
    chk("arst cf", 64'(lu.cf), 64'd0);
    chk("arst busy", 64'(lu.busy), 64'd0);
    chk("arst in_ready", 64'(lu.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op("or_hi_only", 64'h0001_0000_0000_0000, 64'h0, 2'b01, 1'b1,
           64'h0001_0000_0000_0000, 3'b000, 0);

    // Back-to-back: in_valid and out_ready held high; accepts every N+2 = 6 cycles.
    vec[0] = 64'h1111_1111_1111_1111; vec[1] = 64'h2222_2222_2222_2222;
    vec[2] = 64'h3333_3333_3333_3333; vec[3] = 64'h4444_4444_4444_4444;
    lu.b = 64'h00FF_00FF_00FF_00FF; lu.op = 2'b10; lu.set_cc = 1'b0;
    lu.in_valid = 1'b1; lu.out_ready = 1'b1;
    nv = 0; seen_out = 0; exp_cur = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (lu.out_valid) begin
        chk("b2b out", lu.out, exp_cur);
        seen_out++;
      end
      if (lu.in_ready && nv < 4) begin
        acc_cyc.push_back(cyc);
        lu.a    = vec[nv];
        exp_cur = vec[nv] ^ 64'h00FF_00FF_00FF_00FF;
        nv++;
      end
      @(negedge clk);
    end
    lu.in_valid = 1'b0;
    chk("b2b accepts", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd6);
    chk("b2b results", 64'(seen_out), 64'd3);
    chk("b2b cf kept", 64'(lu.cf), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
